// File: rtl/serial_word_loader.sv
// Deserializes a framed, bit-strobed serial stream (start, width data bits MSB first,
// even parity, stop) into one word, with parity, stop-bit and inter-bit timeout checks.
module serial_word_loader #(
    parameter int width   = 15,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             serial_in,
    output logic [width-1:0] data_out,
    output logic             write_enable,
    output logic             parity_error,
    output logic             frame_error,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = (width > 1) ? $clog2(width) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [width-1:0]   shift_q, shift_d;
    logic               par_ok_q, par_ok_d;
    logic [width-1:0]   data_q, data_d;
    logic               we_q, we_d;
    logic               pe_q, pe_d;
    logic               fe_q, fe_d;
    logic               tmo_fire;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        shift_d  = shift_q;
        par_ok_d = par_ok_q;
        data_d   = data_q;
        we_d     = 1'b0;
        pe_d     = 1'b0;
        fe_d     = 1'b0;

        tmo_fire = (state_q != IDLE) && (tmo_q == TMO_W'(TIMEOUT));

        // Gap counter: idle-held, cleared by each strobe, saturating otherwise.
        if (state_q == IDLE || bit_valid) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_W'(TIMEOUT)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        // Timeout takes priority over a strobe arriving in the same cycle.
        if (tmo_fire) begin
            state_d = IDLE;
            cnt_d   = '0;
            tmo_d   = '0;
            fe_d    = 1'b1;
        end else if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (!serial_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d = {shift_q[width-2:0], serial_in};
                    if (cnt_q == CNT_W'(width - 1)) begin
                        state_d = PARITY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    par_ok_d = ~(^shift_q ^ serial_in);
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (!serial_in) begin
                        fe_d = 1'b1;
                    end else if (par_ok_q) begin
                        we_d   = 1'b1;
                        data_d = shift_q;
                    end else begin
                        pe_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tmo_q    <= '0;
            shift_q  <= '0;
            par_ok_q <= 1'b0;
            data_q   <= '0;
            we_q     <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            shift_q  <= shift_d;
            par_ok_q <= par_ok_d;
            data_q   <= data_d;
            we_q     <= we_d;
            pe_q     <= pe_d;
            fe_q     <= fe_d;
        end
    end

    assign data_out     = data_q;
    assign write_enable = we_q;
    assign parity_error = pe_q;
    assign frame_error  = fe_q;
    assign busy         = (state_q != IDLE);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader: good, parity-bad, stop-bad, timeout, mid-frame
// reset and back-to-back frames, with a word scoreboard checked on every write_enable.
module tb_serial_word_loader;

    localparam int W   = 15;
    localparam int TMO = 8;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic         bit_valid = 1'b0;
    logic         serial_in = 1'b0;
    logic [W-1:0] data_out;
    logic         write_enable;
    logic         parity_error;
    logic         frame_error;
    logic         busy;
    logic [1:0]   state_dbg;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int we_cnt      = 0;
    int pe_cnt      = 0;
    int fe_cnt      = 0;
    int last_we_cyc = 0;
    int prev_we_cyc = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_data = '0;

    serial_word_loader #(.width(W), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .write_enable(write_enable),
        .parity_error(parity_error),
        .frame_error (frame_error),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // Clock and cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: pops an expected word on every write_enable, checks data_out holds otherwise.
    always @(negedge clk) begin
        logic multi;
        if (!reset) begin
            exp_data = '0;
            check("rst_data_out", 32'(data_out), 0);
            check("rst_pulses", {29'b0, write_enable, parity_error, frame_error}, 0);
            check("rst_busy", 32'(busy), 0);
        end else begin
            multi = (32'(write_enable) + 32'(parity_error) + 32'(frame_error)) > 1;
            check("pulse_exclusive", 32'(multi), 0);
            if (write_enable === 1'b1) begin
                we_cnt++;
                prev_we_cyc = last_we_cyc;
                last_we_cyc = cyc;
                check("sb_word_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) exp_data = exp_q.pop_front();
            end
            if (parity_error === 1'b1) pe_cnt++;
            if (frame_error === 1'b1) fe_cnt++;
            check("sb_data_out", 32'(data_out), 32'(exp_data));
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bit_valid = 1'b1;
        serial_in = b;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends the first nbits of {start, word, parity, stop}; no idle after the last bit sent.
    task automatic send_frame(input logic [W-1:0] word, input logic par, input logic stop,
                              input int gap, input int nbits);
        logic [W+2:0] f;
        f = {1'b0, word, par, stop};
        for (int i = 0; i < nbits; i++) begin
            drive_bit(f[W+2-i]);
            if (i != nbits - 1) idle(gap);
        end
    endtask

    initial begin
        int we0, pe0, fe0;

        // Reset state
        repeat (2) @(posedge clk);
        sample();
        check("reset_data_out", 32'(data_out), 0);
        check("reset_we", 32'(write_enable), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_state", 32'(state_dbg), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);

        // Good frame 0x5A5A, strobed every 4 cycles
        we0 = we_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
        exp_q.push_back(15'h5A5A);
        send_frame(15'h5A5A, 1'b0, 1'b1, 3, 17);
        idle(3);
        check("good_busy_before_stop", 32'(busy), 1);
        drive_bit(1'b1);
        sample();
        check("good_we_pulse", 32'(write_enable), 1);
        check("good_data_out", 32'(data_out), 32'h5A5A);
        check("good_busy_after", 32'(busy), 0);
        sample();
        check("good_we_one_cycle", 32'(write_enable), 0);
        check("good_we_count", we_cnt - we0, 1);
        check("good_no_errors", (pe_cnt - pe0) + (fe_cnt - fe0), 0);

        // Bad parity: 0x0001 with parity bit 0
        we0 = we_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
        send_frame(15'h0001, 1'b0, 1'b1, 3, 18);
        sample();
        check("par_pe_pulse", 32'(parity_error), 1);
        check("par_data_hold", 32'(data_out), 32'h5A5A);
        sample();
        check("par_pe_one_cycle", 32'(parity_error), 0);
        check("par_no_we", we_cnt - we0, 0);
        check("par_pe_count", pe_cnt - pe0, 1);
        check("par_no_fe", fe_cnt - fe0, 0);

        // Good parity, stop bit 0
        we0 = we_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
        send_frame(15'h2AAA, 1'b1, 1'b0, 3, 18);
        sample();
        check("stop_fe_pulse", 32'(frame_error), 1);
        check("stop_busy", 32'(busy), 0);
        sample();
        check("stop_fe_count", fe_cnt - fe0, 1);
        check("stop_no_we_pe", (we_cnt - we0) + (pe_cnt - pe0), 0);

        // Timeout after start + 5 data bits; a strobe on the firing cycle is ignored
        fe0 = fe_cnt; we0 = we_cnt;
        send_frame(15'h7C00, 1'b0, 1'b1, 3, 6);
        for (int k = 1; k <= TMO + 1; k++) begin
            sample();
            check("tmo_no_fe_yet", 32'(frame_error), 0);
            check("tmo_busy_held", 32'(busy), 1);
            if (k == TMO + 1) begin
                bit_valid = 1'b1;
                serial_in = 1'b1;
            end
            @(posedge clk);
            #1;
            bit_valid = 1'b0;
        end
        sample();
        check("tmo_fe_pulse", 32'(frame_error), 1);
        check("tmo_busy_low", 32'(busy), 0);
        check("tmo_state_idle", 32'(state_dbg), 0);
        exp_q.push_back(15'h7FFF);
        send_frame(15'h7FFF, 1'b1, 1'b1, 3, 18);
        sample();
        check("tmo_next_we", 32'(write_enable), 1);
        check("tmo_next_data", 32'(data_out), 32'h7FFF);
        check("tmo_fe_count", fe_cnt - fe0, 1);

        // Reset mid-frame after 10 data bits, then full 0x1234
        we0 = we_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
        send_frame(15'h1234, 1'b1, 1'b1, 3, 11);
        idle(1);
        check("rstmid_busy_before", 32'(busy), 1);
        reset = 1'b0;
        sample();
        check("rstmid_data_zero", 32'(data_out), 0);
        check("rstmid_busy_zero", 32'(busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(4);
        check("rstmid_no_pulses", (we_cnt - we0) + (pe_cnt - pe0) + (fe_cnt - fe0), 0);
        check("rstmid_data_after", 32'(data_out), 0);
        exp_q.push_back(15'h1234);
        send_frame(15'h1234, 1'b1, 1'b1, 3, 18);
        sample();
        check("rstmid_we", 32'(write_enable), 1);
        check("rstmid_data", 32'(data_out), 32'h1234);

        // Back-to-back frames with bit_valid every cycle
        we0 = we_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
        exp_q.push_back(15'h0003);
        exp_q.push_back(15'h7FFE);
        send_frame(15'h0003, 1'b0, 1'b1, 0, 18);
        send_frame(15'h7FFE, 1'b0, 1'b1, 0, 18);
        sample();
        check("b2b_we2", 32'(write_enable), 1);
        check("b2b_data2", 32'(data_out), 32'h7FFE);
        check("b2b_spacing", last_we_cyc - prev_we_cyc, 18);
        check("b2b_we_count", we_cnt - we0, 2);
        check("b2b_no_errors", (pe_cnt - pe0) + (fe_cnt - fe0), 0);

        idle(3);
        check("final_sb_empty", exp_q.size(), 0);
        check("final_we_total", we_cnt, 5);
        check("final_pe_total", pe_cnt, 1);
        check("final_fe_total", fe_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_loader.md
Name: serial_word_loader

Overview:
- Upstream feeder for the 15-bit capture register. Deserializes a framed, bit-strobed serial stream into one width-bit word.
- Checks parity, stop bit and inter-bit timeout on every frame.
- A good frame produces a one-cycle write_enable with the word on data_out, ready for direct connection to the register's data_in/write_enable.

Parameters:
- width, 15, data bits per frame, which is also the data_out width.
- TIMEOUT, 1023, maximum clk cycles allowed between consecutive bit_valid strobes inside a frame.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- bit_valid  input  1  one-cycle strobe: serial_in holds a valid bit this cycle.
- serial_in  input  1  serial bit, sampled only when bit_valid=1.
- data_out  output  width  last assembled word; drives the register data_in.
- write_enable  output  1  one-cycle pulse: data_out holds a new good word.
- parity_error  output  1  one-cycle pulse: frame rejected on parity.
- frame_error  output  1  one-cycle pulse: frame rejected on bad stop bit or timeout.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Frame format, in bit_valid order:
  - Start bit 0.
  - width data bits, MSB first.
  - Even parity bit: XOR of the data bits plus the parity bit must equal 0.
  - Stop bit 1.
- Reset (reset=0, asynchronous):
  - state=IDLE, bit counter=0, timeout counter=0, shift register=0.
  - data_out=0; write_enable, parity_error, frame_error, busy all 0.
  - Reset asserted mid-frame discards the partial frame and produces no pulses.
- FSM states are IDLE, DATA, PARITY, STOP. A transition happens only on a cycle with bit_valid=1, except for timeout.
  - IDLE: serial_in=0 goes to DATA with bit counter cleared. serial_in=1 is an idle line and is ignored, with no error.
  - DATA: shift the register left, inserting serial_in at the LSB, and increment the counter. When the counter reaches width-1 on a strobe (the last data bit), go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP:
    - serial_in=1 and parity good: data_out <= shift register, write_enable=1 for the next cycle only, go to IDLE.
    - serial_in=1 and parity bad: parity_error pulse, data_out unchanged, go to IDLE.
    - serial_in=0: frame_error pulse, data_out unchanged, go to IDLE. Parity is not reported.
- Latency: write_enable and data_out update in the cycle after the stop-bit strobe, i.e. registered outputs. Error pulses have the same timing.
- Timeout:
  - In any state other than IDLE, the counter increments each cycle without bit_valid and clears on bit_valid.
  - Reaching TIMEOUT produces a frame_error pulse next cycle and a return to IDLE. The partial word is discarded.
  - The counter is held at 0 in IDLE.
- A bit_valid in the same cycle the timeout fires is ignored; timeout wins.
- Back-to-back frames: a start bit strobed on the cycle immediately after the stop bit is accepted, because the FSM is already in IDLE. write_enable of frame N may coincide with the start bit of frame N+1.
- Pulses are mutually exclusive: at most one of write_enable, parity_error, frame_error is high in any cycle.
- busy=1 in DATA, PARITY and STOP; it drops in the cycle after the stop strobe or timeout.
- Bit counter width is clog2(width); it never counts past width-1.
- Timeout counter width is clog2(TIMEOUT+1); it saturates and does not wrap.

Test Plan:
- Good frame 0x5A5A (low 15 bits 0x5A5A; even number of ones, so parity bit 0), strobed every 4 cycles -> one write_enable pulse 1 cycle after the stop strobe, data_out=0x5A5A, no error pulses, busy low afterward.
- Data 0x0001 sent with parity bit 0 (wrong; correct is 1) -> parity_error one cycle, write_enable never high, data_out keeps its previous value.
- Good parity but stop bit 0 -> frame_error one cycle, no write_enable.
- TIMEOUT=8: send start plus 5 data bits, then hold bit_valid low -> frame_error on the 9th idle cycle, busy=0. A following good frame 0x7FFF (parity bit 1) -> write_enable, data_out=0x7FFF.
- reset pulled low for 1 cycle after 10 data bits of a frame, then a complete frame 0x1234 (parity bit 1) -> no pulse from the aborted frame, data_out=0 during and after reset, then write_enable with 0x1234.
- Two frames 0x0003 and 0x7FFE with bit_valid asserted every cycle (no gaps) -> two write_enable pulses 18 cycles apart, data_out 0x0003 then 0x7FFE, no errors.
